// File: rtl/tdma_arbiter.sv
// Work-conserving TDMA arbiter: a slot sequencer rotates ownership of one memory
// port through per-requester slot lengths, and a FREE/BUSY FSM keeps at most one transaction outstanding.
module tdma_arbiter #(
  parameter int NB_PORTS        = 4,
  parameter int COUNTER_WIDTH   = 32,
  parameter bit WORK_CONSERVING = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [COUNTER_WIDTH-1:0]     delta_in [NB_PORTS],
  input  logic                         config_valid,
  input  logic [NB_PORTS-1:0]          request,
  input  logic                         ack,
  output logic [NB_PORTS-1:0]          grant,
  output logic [$clog2(NB_PORTS)-1:0]  slot,
  output logic                         period_start
);

  localparam int SW = $clog2(NB_PORTS);

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;
  typedef logic [SW-1:0]            idx_t;
  typedef enum logic {SEQ_IDLE, SEQ_RUN}   seq_state_e;
  typedef enum logic {GNT_FREE, GNT_BUSY}  gnt_state_e;

  function automatic idx_t wrap_idx(input idx_t base, input int k);
    return idx_t'((int'(base) + k) % NB_PORTS);
  endfunction

  function automatic idx_t first_set(input logic [NB_PORTS-1:0] m);
    idx_t r;
    r = '0;
    for (int i = NB_PORTS - 1; i >= 0; i--) begin
      if (m[i]) r = idx_t'(i);
    end
    return r;
  endfunction

  // First set bit strictly after base (circularly); base itself is the last candidate.
  function automatic idx_t scan_from(input logic [NB_PORTS-1:0] m, input idx_t base);
    idx_t r;
    idx_t idx;
    logic hit;
    r   = base;
    hit = 1'b0;
    for (int k = 1; k <= NB_PORTS; k++) begin
      idx = wrap_idx(base, k);
      if (!hit && m[idx]) begin
        r   = idx;
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [NB_PORTS-1:0] onehot(input idx_t idx);
    logic [NB_PORTS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  seq_state_e          seq_q, seq_d;
  gnt_state_e          gst_q, gst_d;
  cnt_t                active_q [NB_PORTS];
  cnt_t                active_d [NB_PORTS];
  cnt_t                pend_q   [NB_PORTS];
  cnt_t                pend_d   [NB_PORTS];
  logic                pend_vld_q, pend_vld_d;
  cnt_t                count_q, count_d;
  idx_t                slot_q, slot_d;
  logic                ps_q, ps_d;
  logic [NB_PORTS-1:0] grant_q, grant_d;

  logic [NB_PORTS-1:0] active_nz_s;
  logic [NB_PORTS-1:0] pending_nz_s;
  idx_t                first_pend_s;
  idx_t                nxt_s;
  logic                wrap_s;
  logic                apply_s;
  idx_t                alt_s;

  always_comb begin
    active_nz_s  = '0;
    pending_nz_s = '0;
    for (int i = 0; i < NB_PORTS; i++) begin
      active_nz_s[i]  = (active_q[i] != '0);
      pending_nz_s[i] = (pend_q[i] != '0);
    end
    first_pend_s = first_set(pending_nz_s);
    nxt_s        = scan_from(active_nz_s, slot_q);
    alt_s        = scan_from(request, slot_q);
  end

  // A wrap is any advance that does not move to a higher index, including the
  // single-slot case where the owner is reloaded in place.
  assign wrap_s = (nxt_s <= slot_q);

  always_comb begin
    seq_d      = seq_q;
    slot_d     = slot_q;
    count_d    = count_q;
    ps_d       = 1'b0;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    apply_s    = 1'b0;
    case (seq_q)
      SEQ_IDLE: begin
        apply_s = pend_vld_q;
      end
      SEQ_RUN: begin
        if (count_q != '0) begin
          count_d = count_q - cnt_t'(1);
        end else if (wrap_s && pend_vld_q) begin
          apply_s = 1'b1;
        end else begin
          slot_d  = nxt_s;
          count_d = active_q[nxt_s] - cnt_t'(1);
          ps_d    = wrap_s;
        end
      end
      default: begin
        seq_d = SEQ_IDLE;
      end
    endcase

    // Apply happens only at a period boundary or from IDLE, so no slot is ever cut short.
    if (apply_s) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
      if (|pending_nz_s) begin
        seq_d   = SEQ_RUN;
        slot_d  = first_pend_s;
        count_d = pend_q[first_pend_s] - cnt_t'(1);
        ps_d    = 1'b1;
      end else begin
        seq_d   = SEQ_IDLE;
        slot_d  = '0;
        count_d = '0;
      end
    end else begin
      active_d = active_d;
    end

    if (config_valid) begin
      pend_d     = delta_in;
      pend_vld_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  always_comb begin
    gst_d   = gst_q;
    grant_d = grant_q;
    case (gst_q)
      GNT_FREE: begin
        if ((seq_q == SEQ_RUN) && request[slot_q]) begin
          grant_d = onehot(slot_q);
          gst_d   = GNT_BUSY;
        end else if ((seq_q == SEQ_RUN) && WORK_CONSERVING && (|request)) begin
          grant_d = onehot(alt_s);
          gst_d   = GNT_BUSY;
        end else begin
          grant_d = '0;
        end
      end
      GNT_BUSY: begin
        // No preemption: the grant survives slot changes and request drops.
        if (ack) begin
          grant_d = '0;
          gst_d   = GNT_FREE;
        end else begin
          grant_d = grant_q;
        end
      end
      default: begin
        grant_d = '0;
        gst_d   = GNT_FREE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seq_q      <= SEQ_IDLE;
      gst_q      <= GNT_FREE;
      active_q   <= '{default: '0};
      pend_q     <= '{default: '0};
      pend_vld_q <= 1'b0;
      count_q    <= '0;
      slot_q     <= '0;
      ps_q       <= 1'b0;
      grant_q    <= '0;
    end else begin
      seq_q      <= seq_d;
      gst_q      <= gst_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      count_q    <= count_d;
      slot_q     <= slot_d;
      ps_q       <= ps_d;
      grant_q    <= grant_d;
    end
  end

  assign grant        = grant_q;
  assign slot         = slot_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_tdma_arbiter.sv
// Scoreboard bench for tdma_arbiter: directed stimulus pushes expected slot/grant
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_tdma_arbiter;
  localparam int NB = 4;
  localparam int CW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] delta_in [NB];
  logic          config_valid = 1'b0;
  logic [NB-1:0] request = '0;
  logic          ack = 1'b0;
  logic [NB-1:0] grant, grant_s;
  logic [1:0]    slot, slot_s;
  logic          period_start, period_start_s;

  tdma_arbiter #(.NB_PORTS(NB), .COUNTER_WIDTH(CW), .WORK_CONSERVING(1'b1)) dut (
    .clock(clock), .reset(reset), .delta_in(delta_in), .config_valid(config_valid),
    .request(request), .ack(ack), .grant(grant), .slot(slot), .period_start(period_start));

  tdma_arbiter #(.NB_PORTS(NB), .COUNTER_WIDTH(CW), .WORK_CONSERVING(1'b0)) dut_s (
    .clock(clock), .reset(reset), .delta_in(delta_in), .config_valid(config_valid),
    .request(request), .ack(ack), .grant(grant_s), .slot(slot_s), .period_start(period_start_s));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit seq_en = 1'b0, gnt_en = 1'b0, gnt_s_en = 1'b0;

  typedef struct { int slot; bit ps; int cyc; } seq_ev_t;
  typedef struct { logic [NB-1:0] g; int cyc; } gnt_ev_t;
  seq_ev_t sq[$];
  gnt_ev_t gq[$];
  gnt_ev_t gsq[$];
  seq_ev_t se;
  gnt_ev_t ge;
  logic [1:0]    prev_slot = '0;
  logic [NB-1:0] prev_g = '0, prev_gs = '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input int val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event value %0d at cyc %0d", name, val, cyc);
  endtask

  // Monitor: every slot change / period_start pulse / grant change is one event.
  always @(negedge clock) begin
    if (reset) begin
      if (seq_en && (slot != prev_slot || period_start)) begin
        if (sq.size() == 0) unexpected("seq_event", int'(slot));
        else begin
          se = sq.pop_front();
          check("seq_slot", int'(slot), se.slot);
          check("seq_period_start", int'(period_start), int'(se.ps));
          check("seq_cycle", cyc, se.cyc);
        end
      end
      if (gnt_en && grant != prev_g) begin
        if (gq.size() == 0) unexpected("grant_event", int'(grant));
        else begin
          ge = gq.pop_front();
          check("grant_value", int'(grant), int'(ge.g));
          check("grant_cycle", cyc, ge.cyc);
        end
      end
      if (gnt_s_en && grant_s != prev_gs) begin
        if (gsq.size() == 0) unexpected("strict_grant_event", int'(grant_s));
        else begin
          ge = gsq.pop_front();
          check("strict_grant_value", int'(grant_s), int'(ge.g));
          check("strict_grant_cycle", cyc, ge.cyc);
        end
      end
    end
    prev_slot = slot;
    prev_g    = grant;
    prev_gs   = grant_s;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic do_reset();
    seq_en = 1'b0; gnt_en = 1'b0; gnt_s_en = 1'b0;
    request = '0; ack = 1'b0; config_valid = 1'b0;
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic configure(input int d0, input int d1, input int d2, input int d3, output int c);
    delta_in[0] = d0; delta_in[1] = d1; delta_in[2] = d2; delta_in[3] = d3;
    config_valid = 1'b1;
    c = cyc;
    tick(1);
    config_valid = 1'b0;
  endtask

  // Expected timeline: each nonzero slot lasts exactly its delta, first slot of a period pulses.
  task automatic push_seq(input int d0, input int d1, input int d2, input int d3,
                          input int s, input int periods, output int t_end);
    int d[NB];
    int t;
    bit first;
    d = '{d0, d1, d2, d3};
    t = s;
    for (int p = 0; p < periods; p++) begin
      first = 1'b1;
      for (int i = 0; i < NB; i++) begin
        if (d[i] != 0) begin
          sq.push_back('{i, first, t});
          first = 1'b0;
          t += d[i];
        end
      end
    end
    t_end = t;
  endtask

  task automatic run_seq(input int d0, input int d1, input int d2, input int d3, input int periods);
    int c, t_end;
    do_reset();
    seq_en = 1'b1;
    configure(d0, d1, d2, d3, c);
    push_seq(d0, d1, d2, d3, c + 2, periods, t_end);
    wait_cyc(t_end);
    seq_en = 1'b0;
    check("seq_missing_events", sq.size(), 0);
    sq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s, t1, t2;
    for (int i = 0; i < NB; i++) delta_in[i] = '0;

    // Reset held with all requests high.
    request = 4'b1111;
    repeat (4) begin
      @(negedge clock);
      check("reset_grant", int'(grant), 0);
      check("reset_slot", int'(slot), 0);
    end
    @(posedge clock); #2;
    reset = 1'b1;
    tick(1);
    gnt_en = 1'b1; seq_en = 1'b1;
    tick(100);
    check("noconfig_grant", int'(grant), 0);
    check("noconfig_slot", int'(slot), 0);
    gnt_en = 1'b0; seq_en = 1'b0;

    run_seq(15, 15, 15, 15, 3);
    run_seq(4, 0, 16, 0, 3);
    run_seq(32, 0, 0, 0, 3);

    // Owner priority and no preemption across a slot boundary.
    do_reset();
    configure(15, 15, 15, 15, c);
    s = c + 2;
    gnt_en = 1'b1;
    wait_cyc(s + 27);
    request = 4'b0110;
    gq.push_back('{4'b0010, s + 28});
    gq.push_back('{4'b0000, s + 33});
    gq.push_back('{4'b0100, s + 34});
    gq.push_back('{4'b0000, s + 36});
    wait_cyc(s + 31);
    check("hold_grant", int'(grant), 2);
    check("hold_slot", int'(slot), 2);
    wait_cyc(s + 32); ack = 1'b1;
    wait_cyc(s + 33); ack = 1'b0;
    wait_cyc(s + 35); ack = 1'b1;
    wait_cyc(s + 36); ack = 1'b0; request = '0;
    wait_cyc(s + 40);
    gnt_en = 1'b0;
    check("owner_missing_events", gq.size(), 0);
    gq.delete();

    // Work conservation vs strict TDMA.
    do_reset();
    configure(15, 15, 15, 15, c);
    s = c + 2;
    gnt_en = 1'b1; gnt_s_en = 1'b1;
    wait_cyc(s + 3);
    request = 4'b1010;
    gq.push_back('{4'b0010, s + 4});
    gq.push_back('{4'b0000, s + 21});
    gsq.push_back('{4'b0010, s + 16});
    gsq.push_back('{4'b0000, s + 21});
    wait_cyc(s + 10);
    check("strict_idle_grant", int'(grant_s), 0);
    check("strict_slot_match", int'(slot_s), int'(slot));
    check("strict_ps_match", int'(period_start_s), int'(period_start));
    wait_cyc(s + 20); ack = 1'b1;
    wait_cyc(s + 21); ack = 1'b0; request = '0;
    wait_cyc(s + 25);
    gnt_en = 1'b0; gnt_s_en = 1'b0;
    check("wc_missing_events", gq.size(), 0);
    check("strict_missing_events", gsq.size(), 0);
    gq.delete(); gsq.delete();

    // Reconfiguration mid-period, then reset while BUSY.
    do_reset();
    seq_en = 1'b1;
    configure(15, 15, 15, 15, c);
    s = c + 2;
    push_seq(15, 15, 15, 15, s, 1, t1);
    push_seq(4, 8, 16, 32, t1, 1, t2);
    sq.push_back('{0, 1'b1, t2});
    wait_cyc(s + 20);
    configure(4, 8, 16, 32, c);
    wait_cyc(t2 + 1);
    seq_en = 1'b0;
    check("reconfig_missing_events", sq.size(), 0);
    sq.delete();
    request = 4'b0001;
    tick(3);
    check("busy_grant", int'(grant), 1);
    reset = 1'b0;
    #1;
    check("async_reset_grant", int'(grant), 0);
    check("async_reset_slot", int'(slot), 0);
    tick(2);
    reset = 1'b1;
    tick(5);
    check("post_reset_idle_grant", int'(grant), 0);
    check("post_reset_idle_slot", int'(slot), 0);
    check("post_reset_idle_ps", int'(period_start), 0);
    request = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
